keypad_scanner: RTL

Scans the 4x4 matrix keypad on the board and delivers debounced, one-shot key events to the elevator controller. It drives `keyb_row`, samples `keyb_col`, and emits a single-cycle `key_valid` pulse with a 4-bit `key_code` for each accepted press. It sits directly upstream of the elevator control logic, replacing raw row/column handling inside it.

---
 rtl/keypad_pkg.sv | 41 ++++
 rtl/keypad_scanner_if.sv | 28 ++
 rtl/keypad_scanner_scan_tick.sv | 38 +++
 rtl/keypad_scanner.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types, constants and the column priority encoder
//                used by the 4x4 keypad scanner.
//  Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  typedef logic [3:0] key_code_t;

  // Row 0 driven low, all other rows released.
  localparam logic [3:0] ROW_RESET = 4'b1110;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } col_dec_t;

  // Active-low priority encoder: the lowest-index low bit wins.
  function automatic col_dec_t col_encode(input logic [3:0] bits_n);
    col_dec_t r;
    r.valid = 1'b0;
    r.idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!bits_n[i]) begin
        r.valid = 1'b1;
        r.idx   = 2'(i);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Keypad matrix pins plus the key-event bus toward the
//                elevator controller. The scanner takes the master side.
//  Revision    : 1.0  initial release
// ============================================================================
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [3:0] keyb_col;   // active-low columns, pulled up externally
  logic [3:0] keyb_row;   // one-hot active-low row drive
  logic       key_valid;  // one-cycle accepted-press pulse
  key_code_t  key_code;   // row*4 + col of last accepted key
  logic       key_held;   // accepted press until accepted release

  modport master (
    input  keyb_col,
    output keyb_row, key_valid, key_code, key_held
  );

  modport slave (
    output keyb_col,
    input  keyb_row, key_valid, key_code, key_held
  );

endinterface
`default_nettype wire

// File: rtl/keypad_scanner_scan_tick.sv
`default_nettype none
// ============================================================================
//  Module      : scan_tick
//  Description : Free-running dwell counter 0..DWELL_CYCLES-1 producing a
//                single-cycle strobe on its last count. Also suitable for
//                display digit multiplexing.
//  Revision    : 1.0  initial release
// ============================================================================
module scan_tick #(
  parameter int unsigned DWELL_CYCLES = 100_000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  output logic      o_tick
);

  localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == C_LAST);
  assign o_tick = w_last;

  // Count up and wrap to zero after the last dwell cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner with press/release debounce.
//                Emits one key_valid pulse with key_code per accepted press.
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES   = 100_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  keypad_scanner_if.master  kp
);

  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] C_SCANS = CW'(DEBOUNCE_SCANS);

  logic            w_tick;
  logic [3:0]      r_sync1, r_sync2;
  col_dec_t        w_dec;
  key_code_t       w_sample_code;

  kp_state_t       r_state, w_state;
  logic [1:0]      r_row_idx, w_row_idx;
  logic [3:0]      r_row, w_row;
  key_code_t       r_cand, w_cand;
  logic [CW-1:0]   r_cnt, w_cnt, w_cnt_inc;
  logic [CW-1:0]   r_rel_cnt, w_rel_cnt, w_rel_inc;
  logic            r_key_valid, w_key_valid;
  key_code_t       r_key_code, w_key_code;
  logic            r_key_held, w_key_held;
  logic            w_enter, w_advance;

  scan_tick #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_scan_tick (
    .clk    (clk),
    .rst_n  (reset_n),
    .o_tick (w_tick)
  );

  // Two-flop synchronizer on the asynchronous column inputs (idle high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= kp.keyb_col;
      r_sync2 <= r_sync1;
    end
  end

  assign w_dec         = col_encode(r_sync2);
  assign w_sample_code = {r_row_idx, w_dec.idx};
  assign w_cnt_inc     = r_cnt + CW'(1);
  assign w_rel_inc     = r_rel_cnt + CW'(1);

  // Next-state and output decode; everything only moves on a sample strobe.
  always_comb begin
    w_state     = r_state;
    w_row_idx   = r_row_idx;
    w_row       = r_row;
    w_cand      = r_cand;
    w_cnt       = r_cnt;
    w_rel_cnt   = r_rel_cnt;
    w_key_valid = 1'b0;
    w_key_code  = r_key_code;
    w_key_held  = r_key_held;
    w_enter     = 1'b0;
    w_advance   = 1'b0;

    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_dec.valid) begin
            w_cand = w_sample_code;
            w_cnt  = CW'(1);
            if (C_SCANS == CW'(1)) begin
              w_enter = 1'b1;
            end else begin
              w_state = DEBOUNCE;
            end
          end else begin
            w_advance = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (w_dec.valid && (w_sample_code == r_cand)) begin
            w_cnt = w_cnt_inc;
            if (w_cnt_inc == C_SCANS) begin
              w_enter = 1'b1;
            end
          end else begin
            w_state   = SCAN;
            w_advance = 1'b1;
          end
        end
        HELD: begin
          // Any column in the frozen row keeps the key counted as held.
          if (w_dec.valid) begin
            w_rel_cnt = '0;
          end else if (w_rel_inc == C_SCANS) begin
            w_rel_cnt  = '0;
            w_state    = SCAN;
            w_key_held = 1'b0;
            w_advance  = 1'b1;
          end else begin
            w_rel_cnt = w_rel_inc;
          end
        end
        default: begin
          w_state = SCAN;
        end
      endcase
    end

    if (w_enter) begin
      w_state     = HELD;
      w_key_valid = 1'b1;
      w_key_code  = w_cand;
      w_key_held  = 1'b1;
      w_rel_cnt   = '0;
    end

    if (w_advance) begin
      w_row_idx = r_row_idx + 2'd1;
      w_row     = ~(4'b0001 << w_row_idx);
    end
  end

  // State, row drive, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SCAN;
      r_row_idx   <= 2'd0;
      r_row       <= ROW_RESET;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_rel_cnt   <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_row_idx   <= w_row_idx;
      r_row       <= w_row;
      r_cand      <= w_cand;
      r_cnt       <= w_cnt;
      r_rel_cnt   <= w_rel_cnt;
      r_key_valid <= w_key_valid;
      r_key_code  <= w_key_code;
      r_key_held  <= w_key_held;
    end
  end

  assign kp.keyb_row  = r_row;
  assign kp.key_valid = r_key_valid;
  assign kp.key_code  = r_key_code;
  assign kp.key_held  = r_key_held;

endmodule
`default_nettype wire
